instruction_fetch_sequencer: RTL
================================

Name: instruction_fetch_sequencer

Overview:
- Multi-cycle stage sequencer and instruction-fetch responder for the RISC-V core.
- Drives the 2-bit `stage` bus that the program counter consumes; the PC advances on the clock edge that ends stage 3.
- Takes the current PC, fetches the instruction word over a req/ready memory handshake, and holds it in the instruction register for the decode, execute and writeback stages.
- Adds alignment checking, a fetch timeout and a pipeline stall.

Parameters:
- TIMEOUT_CYCLES, 15, fetch wait cycles before abort; 0 disables the timeout.
- NOP_INSTR, 32'h00000013, word loaded on reset, fault or timeout (addi x0,x0,0).
- CNT_WIDTH, 4, width of the wait counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- PC  input  32  current program counter from the PC block.
- stall  input  1  freezes the sequencer in stages 1-3.
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  32  word-aligned fetch address, {PC[31:2],2'b00}.
- mem_ready  input  1  memory has mem_rdata valid this cycle.
- mem_rdata  input  32  instruction word from memory.
- instruction  output  32  latched instruction for decode/execute.
- stage  output  2  0=FETCH, 1=DECODE, 2=EXEC, 3=WB.
- fetch_fault  output  1  current instruction is a substituted NOP due to misalignment or timeout.

Behaviour:
- Reset (Reset=0, asynchronous, takes effect immediately):
  - stage=3 (WB), instruction=NOP_INSTR, fetch_fault=0, wait counter=0, mem_req=0.
  - On release, the first edge moves WB to FETCH. That same edge advances the PC from its reset value to 0, so the first fetch is at address 0.
- State machine: one state per stage value.
  - WB -> FETCH, DECODE -> EXEC, EXEC -> WB: one cycle each when stall=0; the state holds while stall=1.
  - stall is ignored in FETCH.
- FETCH with aligned PC (PC[1:0]==0):
  - mem_req=1 combinationally; mem_addr is driven from PC.
  - On an edge with mem_ready=1: instruction<=mem_rdata, fetch_fault<=0, counter<=0, stage->DECODE.
  - Minimum fetch latency is 1 cycle (ready in the first FETCH cycle).
- FETCH with misaligned PC:
  - mem_req=0; no request is issued.
  - At the next edge: instruction<=NOP_INSTR, fetch_fault<=1, stage->DECODE.
- Timeout:
  - Each FETCH cycle with mem_req=1 and mem_ready=0 increments the counter.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 at such an edge: instruction<=NOP_INSTR, fetch_fault<=1, counter<=0, stage->DECODE. This gives TIMEOUT_CYCLES FETCH cycles in total.
  - mem_ready=1 on the final cycle wins over timeout; the data is taken.
- mem_req is 0 in all states other than FETCH. mem_ready/mem_rdata are ignored outside FETCH.
- instruction and fetch_fault change only on a FETCH->DECODE transition or reset. They are stable through DECODE, EXEC and WB, including during stall.
- Reset asserted mid-fetch: mem_req drops in the same cycle. Any pending memory response after reset release is ignored until the next FETCH; memory must tolerate an abandoned request.
- Counter saturates at 2^CNT_WIDTH-1 when TIMEOUT_CYCLES=0 (no wrap, no effect).
- mem_addr = {PC[31:2],2'b00} is a continuous assignment in all states; it is meaningful only when mem_req=1.

Test Plan:
- Reset release, PC=0, mem_ready=1 immediately: stage sequence 3,0,1,2,3,0 on consecutive cycles; mem_req=1 for 1 cycle; instruction=mem_rdata (e.g. 32'h00500093) from the first DECODE cycle; fetch_fault=0.
- PC=32'h00000010, mem_ready asserted on the 4th FETCH cycle with rdata 32'hDEADBEEF: stage=0 for 4 cycles; mem_addr=32'h10 throughout; instruction=32'hDEADBEEF; counter cleared.
- PC=32'h00000006: mem_req never asserts; after one FETCH cycle instruction=32'h00000013 and fetch_fault=1; fault clears after the next good fetch.
- mem_ready held 0, TIMEOUT_CYCLES=15: exactly 15 FETCH cycles with mem_req=1, then DECODE with NOP and fault=1. Variant with ready on cycle 15: data accepted and fault=0.
- stall=1 for 3 cycles entering EXEC: stage=2 for 4 cycles, instruction unchanged. Variant with stall=1 during FETCH: FETCH exits normally on ready.
- Reset pulsed low during the 2nd FETCH cycle: mem_req=0 and stage=3 within the same cycle, instruction=NOP; after release the fetch restarts at PC=0.

Source files
------------

// File: rtl/instruction_fetch_sequencer.sv
// Stage sequencer (FETCH/DECODE/EXEC/WB) with instruction fetch over a req/ready handshake.
// Misaligned PC or fetch timeout substitutes NOP_INSTR and raises fetch_fault.
//
// state    | meaning
// S_FETCH  | request word at PC, wait for ready / timeout / misalign
// S_DECODE | instruction register stable for decode
// S_EXEC   | instruction register stable for execute
// S_WB     | writeback; PC advances on the edge leaving this state
module instruction_fetch_sequencer #(
    parameter int          TIMEOUT_CYCLES = 15,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int          CNT_WIDTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_instruction,
    output logic [1:0]  o_stage,
    output logic        o_fetch_fault
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = TIMEOUT_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    state_t               r_state;
    logic [31:0]          r_instr;
    logic                 r_fault;
    logic [CNT_WIDTH-1:0] r_cnt;

    state_t               w_state_nxt;
    logic [31:0]          w_instr_nxt;
    logic                 w_fault_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_aligned;

    assign w_aligned     = (i_pc[1:0] == 2'b00);
    assign o_mem_addr    = {i_pc[31:2], 2'b00};
    assign o_instruction = r_instr;
    assign o_fetch_fault = r_fault;
    assign o_stage       = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_WB;
            r_instr <= NOP_INSTR;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_instr <= w_instr_nxt;
            r_fault <= w_fault_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_instr_nxt = r_instr;
        w_fault_nxt = r_fault;
        w_cnt_nxt   = r_cnt;
        o_mem_req   = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (!w_aligned) begin
                    w_instr_nxt = NOP_INSTR;
                    w_fault_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DECODE;
                end else begin
                    o_mem_req = 1'b1;
                    // Ready on the last allowed cycle still wins over the timeout.
                    if (i_mem_ready) begin
                        w_instr_nxt = i_mem_rdata;
                        w_fault_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DECODE;
                    end else if (TIMEOUT_EN && (r_cnt == CNT_LAST)) begin
                        w_instr_nxt = NOP_INSTR;
                        w_fault_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DECODE;
                    end else if (r_cnt != CNT_MAX) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_DECODE: if (!i_stall) w_state_nxt = S_EXEC;
            S_EXEC:   if (!i_stall) w_state_nxt = S_WB;
            default:  if (!i_stall) w_state_nxt = S_FETCH;
        endcase
    end

endmodule
